demux_1to8_buf: RTL and testbench

DEMUX_1TO8_BUF -- requirements
Module: demux_1to8_buf

---
 rtl/demux_1to8_buf.sv | 78 +++++++
 tb/tb_demux_1to8_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to8_buf.sv
// One-to-eight demultiplexer with a single-entry skid-free buffer per lane.
// Each lane is a registered valid/data pair with independent ready/valid handshakes.
module demux_1to8_buf #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic [3:0]           occupancy,
    output logic [15:0]          accept_count
);

    logic [7:0]  valid_q;
    logic [7:0]  valid_d;
    logic [3:0]  occ_q;
    logic [3:0]  occ_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        accept;

    // A full lane can still take a new word when its consumer drains on the same edge.
    assign in_ready = !valid_q[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic             load;
            logic             drain;
            logic [WIDTH-1:0] data_q;

            assign load         = accept && (in_sel == 3'(gi));
            assign drain        = valid_q[gi] && out_ready[gi];
            assign valid_d[gi]  = load || (valid_q[gi] && !drain);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (load) begin
                    data_q <= in_data;
                end
            end

            assign out_data[gi*WIDTH +: WIDTH] = data_q;
        end
    endgenerate

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < 8; i++) begin
            occ_d = occ_d + 4'(valid_d[i]);
        end
    end

    assign cnt_d = cnt_q + 16'(accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign occupancy    = occ_q;
    assign accept_count = cnt_q;

endmodule

// File: tb/tb_demux_1to8_buf.sv
// Scoreboard bench for demux_1to8_buf: stimulus pushes per-lane expectations,
// a negedge monitor pops and checks each word as its lane drains.
module tb_demux_1to8_buf;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [8*W-1:0] out_data;
    logic [3:0]     occupancy;
    logic [15:0]    accept_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit strict_lat  = 1'b0;

    typedef struct {
        logic [W-1:0] data;
        int           acc_cyc;
        bit           strict;
    } exp_t;

    exp_t lane_q [8][$];

    demux_1to8_buf #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_data(input int l);
        return out_data[l*W +: W];
    endfunction

    // Called at posedge+1; returns at the following posedge+1 with new state visible.
    task automatic step(input bit v, input logic [2:0] s, input logic [W-1:0] d,
                        input logic [7:0] ordy, input bit exp_rdy);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        if (v) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (exp_rdy) begin
                exp_t e;
                e.data    = d;
                e.acc_cyc = cyc;
                e.strict  = strict_lat;
                lane_q[s].push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int l = 0; l < 8; l++) begin
                if (out_valid[l] && out_ready[l]) begin
                    if (lane_q[l].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL lane%0d_unexpected: got data 0x%0h, expected no output", l, lane_data(l));
                    end else begin
                        e = lane_q[l].pop_front();
                        chk($sformatf("lane%0d_data", l), lane_data(l), e.data);
                        if (e.strict)
                            chk($sformatf("lane%0d_latency", l), cyc - e.acc_cyc, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int fill_a [6] = '{0, 1, 2, 4, 6, 7};
        int fill_b [4] = '{1, 2, 6, 7};
        int left;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = '0;
        out_ready = 8'h00;
        #12;
        chk("rst_out_valid", {24'd0, out_valid}, 32'd0);
        chk("rst_occupancy", {28'd0, occupancy}, 32'd0);
        chk("rst_accept_count", {16'd0, accept_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_lane0_data", lane_data(0), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write to lane 3, consumer stalled
        step(1'b1, 3'd3, 32'hA5A5_0003, 8'h00, 1'b1);
        chk("w3_out_valid", {24'd0, out_valid}, 32'h08);
        chk("w3_data", lane_data(3), 32'hA5A5_0003);
        chk("w3_occupancy", {28'd0, occupancy}, 32'd1);
        chk("w3_accept_count", {16'd0, accept_count}, 32'd1);

        // Second write to the full, stalled lane is refused
        step(1'b1, 3'd3, 32'h0000_0055, 8'h00, 1'b0);
        chk("w3b_data", lane_data(3), 32'hA5A5_0003);
        chk("w3b_accept_count", {16'd0, accept_count}, 32'd1);
        chk("w3b_occupancy", {28'd0, occupancy}, 32'd1);

        // Idle cycle with garbage on sel/data changes nothing
        step(1'b0, 3'd3, 32'hFFFF_FFFF, 8'h00, 1'b0);
        chk("idle_data", lane_data(3), 32'hA5A5_0003);
        chk("idle_accept_count", {16'd0, accept_count}, 32'd1);

        // Lane 5: fill, then replace while draining on the same edge
        step(1'b1, 3'd5, 32'h0000_0777, 8'h00, 1'b1);
        chk("w5_occupancy", {28'd0, occupancy}, 32'd2);
        chk("w5_accept_count", {16'd0, accept_count}, 32'd2);
        step(1'b1, 3'd5, 32'h0000_1234, 8'h20, 1'b1);
        chk("w5r_out_valid", {24'd0, out_valid}, 32'h28);
        chk("w5r_data", lane_data(5), 32'h0000_1234);
        chk("w5r_occupancy", {28'd0, occupancy}, 32'd2);
        chk("w5r_accept_count", {16'd0, accept_count}, 32'd3);

        // Fill all remaining lanes
        foreach (fill_a[k])
            step(1'b1, 3'(fill_a[k]), 32'h100 + 32'(fill_a[k]), 8'h00, 1'b1);
        chk("full_out_valid", {24'd0, out_valid}, 32'hFF);
        chk("full_occupancy", {28'd0, occupancy}, 32'd8);
        chk("full_accept_count", {16'd0, accept_count}, 32'd9);
        step(1'b1, 3'd6, 32'hDEAD_0006, 8'h00, 1'b0);
        chk("full_refuse_count", {16'd0, accept_count}, 32'd9);

        // Drain lane 2 only: others untouched, empty lane keeps its data
        step(1'b0, 3'd2, 32'hFFFF_FFFF, 8'h04, 1'b0);
        chk("d2_out_valid", {24'd0, out_valid}, 32'hFB);
        chk("d2_occupancy", {28'd0, occupancy}, 32'd7);
        chk("d2_data_retained", lane_data(2), 32'h102);

        // Drain everything in one cycle
        step(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0);
        chk("dall_out_valid", {24'd0, out_valid}, 32'h00);
        chk("dall_occupancy", {28'd0, occupancy}, 32'd0);

        // Four lanes full, then asynchronous reset mid-cycle
        foreach (fill_b[k])
            step(1'b1, 3'(fill_b[k]), 32'h200 + 32'(fill_b[k]), 8'h00, 1'b1);
        chk("f4_occupancy", {28'd0, occupancy}, 32'd4);
        chk("f4_accept_count", {16'd0, accept_count}, 32'd13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {24'd0, out_valid}, 32'd0);
        chk("arst_occupancy", {28'd0, occupancy}, 32'd0);
        chk("arst_accept_count", {16'd0, accept_count}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_lane6_data", lane_data(6), 32'd0);
        for (int l = 0; l < 8; l++) lane_q[l].delete();
        in_valid = 1'b1;
        in_sel   = 3'd2;
        in_data  = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        chk("inrst_accept_count", {16'd0, accept_count}, 32'd0);
        chk("inrst_out_valid", {24'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // 65536 back-to-back accepts with all consumers ready
        strict_lat = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, i[2:0], W'(i) * 32'h9E37_79B1, 8'hFF, 1'b1);
            if (i == 65534)
                chk("wrap_acc_ffff", {16'd0, accept_count}, 32'hFFFF);
        end
        chk("wrap_acc_zero", {16'd0, accept_count}, 32'd0);
        chk("wrap_occupancy", {28'd0, occupancy}, 32'd1);
        step(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0);
        chk("wrap_drained", {28'd0, occupancy}, 32'd0);
        strict_lat = 1'b0;

        for (int t = 0; t < 20; t++) begin
            left = 0;
            for (int l = 0; l < 8; l++) left += lane_q[l].size();
            if (left == 0) break;
            step(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0);
        end
        left = 0;
        for (int l = 0; l < 8; l++) left += lane_q[l].size();
        chk("undelivered_words", left, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
